// File: rtl/i2c_sb_pkg.sv
// Shared constants for the I2C hard-IP system-bus register interface.
// Holds register offsets, CR1/CMDR command bits, SR bit indices, the sequencer
// state type and a small helper that forms a full system-bus address.
package i2c_sb_pkg;

  // Register offsets (low nibble of sbadr).
  localparam logic [3:0] OffCr1   = 4'h8;
  localparam logic [3:0] OffCmdr  = 4'h9;
  localparam logic [3:0] OffBrlsb = 4'hA;
  localparam logic [3:0] OffBrmsb = 4'hB;
  localparam logic [3:0] OffSr    = 4'hC;
  localparam logic [3:0] OffTxdr  = 4'hD;

  // CR1 bits.
  localparam logic [7:0] Cr1I2cEn = 8'h80;

  // CMDR bits.
  localparam logic [7:0] CmdrSta = 8'h80;
  localparam logic [7:0] CmdrSto = 8'h40;
  localparam logic [7:0] CmdrWr  = 8'h10;

  // SR bit indices.
  localparam int unsigned SrTip   = 7;
  localparam int unsigned SrBusy  = 6;
  localparam int unsigned SrRarc  = 5;
  localparam int unsigned SrTrrdy = 2;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StSendAddr,
    StPoll,
    StLoad,
    StSendByte,
    StStop
  } seq_state_e;

  function automatic logic [7:0] sb_addr(input logic [3:0] base, input logic [3:0] off);
    return {base, off};
  endfunction

endpackage

// File: rtl/sb_access.sv
// Single system-bus access engine with per-access timeout.
// A req_i pulse while idle launches one access; strobe, direction, address and
// write data are held from launch until the cycle sback_i is seen, and the
// strobe drops on the following cycle. ack_o pulses (with rdata_o valid) in that
// first idle cycle. If sback_i never arrives within TIMEOUT cycles the strobe is
// dropped and timeout_o pulses instead.
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   req_i/we_i/addr_i/wdata_i  access launch request and its parameters
//   ack_o/rdata_o/timeout_o    completion pulse, read data, timeout pulse
//   sbstb_o/sbrw_o/sbadr_o/sbdat_o  system-bus master outputs
//   sback_i/sbdat_i        system-bus acknowledge and read data
module sb_access #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic       we_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       ack_o,
  output logic [7:0] rdata_o,
  output logic       timeout_o,
  output logic       sbstb_o,
  output logic       sbrw_o,
  output logic [7:0] sbadr_o,
  output logic [7:0] sbdat_o,
  input  logic       sback_i,
  input  logic [7:0] sbdat_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic            stb_q, stb_d;
  logic            we_q, we_d;
  logic [7:0]      adr_q, adr_d;
  logic [7:0]      dat_q, dat_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            ack_q, ack_d;
  logic            to_q, to_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    to_d    = 1'b0;
    if (!stb_q) begin
      if (req_i) begin
        stb_d = 1'b1;
        we_d  = we_i;
        adr_d = addr_i;
        dat_d = wdata_i;
        cnt_d = '0;
      end
    end else if (sback_i) begin
      stb_d = 1'b0;
      ack_d = 1'b1;
      if (!we_q) begin
        rdata_d = sbdat_i;
      end
    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
      stb_d = 1'b0;
      to_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      to_q    <= to_d;
    end
  end

  assign ack_o     = ack_q;
  assign rdata_o   = rdata_q;
  assign timeout_o = to_q;
  assign sbstb_o   = stb_q;
  assign sbrw_o    = we_q;
  assign sbadr_o   = adr_q;
  assign sbdat_o   = dat_q;

endmodule

// File: rtl/i2c_write_sequencer.sv
// I2C write-transaction sequencer driving a hard I2C IP over its system bus.
// After reset it programs the baud prescaler and enables the core, then accepts
// write commands (7-bit slave address + 0..15 payload bytes), issues START+addr,
// streams payload bytes, and finishes with STOP, reporting NACK or timeout.
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o        command handshake; cmd_addr_i, cmd_len_i
//   wr_data_i/wr_valid_i/wr_ready_o  payload byte stream
//   done_o                         one-cycle pulse at transaction end
//   nack_o, timeout_o              status of last transaction
//   busy_o                         high outside IDLE
//   sbrw_o/sbstb_o/sbadr_o/sbdat_to_peripheral_o  system-bus master
//   sbdat_from_peripheral_i/sback_i               system-bus response
module i2c_write_sequencer
  import i2c_sb_pkg::*;
#(
  parameter logic [3:0]  BUS_ADDR74 = 4'b0001,
  parameter logic [9:0]  PRESCALE   = 10'd30,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [6:0] cmd_addr_i,
  input  logic [3:0] cmd_len_i,
  input  logic [7:0] wr_data_i,
  input  logic       wr_valid_i,
  output logic       wr_ready_o,
  output logic       done_o,
  output logic       nack_o,
  output logic       timeout_o,
  output logic       busy_o,
  output logic       sbrw_o,
  output logic       sbstb_o,
  output logic [7:0] sbadr_o,
  output logic [7:0] sbdat_to_peripheral_o,
  input  logic [7:0] sbdat_from_peripheral_i,
  input  logic       sback_i
);

  seq_state_e state_q, state_d;
  logic [1:0] step_q, step_d;      // access index within the current state
  logic       issued_q, issued_d;  // current step's access is in flight
  logic [6:0] addr_q, addr_d;
  logic [3:0] left_q, left_d;      // payload bytes still to send
  logic [7:0] byte_q, byte_d;
  logic       nack_q, nack_d;
  logic       to_q, to_d;
  logic       done_q, done_d;

  logic       acc_req;
  logic       acc_we;
  logic [3:0] acc_off;
  logic [7:0] acc_wdata;
  logic       acc_ack;
  logic       acc_to;
  logic [7:0] acc_rdata;
  logic       unused_sr;

  assign unused_sr = ^{acc_rdata[4:3], acc_rdata[1:0]};

  sb_access #(
    .TIMEOUT(TIMEOUT)
  ) u_sb_access (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (acc_req),
    .we_i     (acc_we),
    .addr_i   (sb_addr(BUS_ADDR74, acc_off)),
    .wdata_i  (acc_wdata),
    .ack_o    (acc_ack),
    .rdata_o  (acc_rdata),
    .timeout_o(acc_to),
    .sbstb_o  (sbstb_o),
    .sbrw_o   (sbrw_o),
    .sbadr_o  (sbadr_o),
    .sbdat_o  (sbdat_to_peripheral_o),
    .sback_i  (sback_i),
    .sbdat_i  (sbdat_from_peripheral_i)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StInit;
      step_q   <= '0;
      issued_q <= 1'b0;
      addr_q   <= '0;
      left_q   <= '0;
      byte_q   <= '0;
      nack_q   <= 1'b0;
      to_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      issued_q <= issued_d;
      addr_q   <= addr_d;
      left_q   <= left_d;
      byte_q   <= byte_d;
      nack_q   <= nack_d;
      to_q     <= to_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    issued_d = issued_q;
    addr_d   = addr_q;
    left_d   = left_q;
    byte_d   = byte_q;
    nack_d   = nack_q;
    to_d     = to_q;
    done_d   = 1'b0;
    if (acc_req) begin
      issued_d = 1'b1;
    end
    unique case (state_q)
      StInit: begin
        // A dead bus during init is not reported; the sequence just moves on.
        if (acc_ack || acc_to) begin
          issued_d = 1'b0;
          if (step_q == 2'd2) begin
            state_d = StIdle;
            step_d  = '0;
          end else begin
            step_d = step_q + 2'd1;
          end
        end
      end
      StIdle: begin
        if (cmd_valid_i) begin
          addr_d   = cmd_addr_i;
          left_d   = cmd_len_i;
          nack_d   = 1'b0;
          to_d     = 1'b0;
          state_d  = StSendAddr;
          step_d   = '0;
          issued_d = 1'b0;
        end
      end
      StSendAddr, StSendByte: begin
        if (acc_to) begin
          to_d     = 1'b1;
          issued_d = 1'b0;
          state_d  = StStop;
          step_d   = '0;
        end else if (acc_ack) begin
          issued_d = 1'b0;
          if (step_q == 2'd0) begin
            step_d = 2'd1;
          end else begin
            state_d = StPoll;
            step_d  = '0;
          end
        end
      end
      StPoll: begin
        if (acc_to) begin
          to_d     = 1'b1;
          issued_d = 1'b0;
          state_d  = StStop;
          step_d   = '0;
        end else if (acc_ack) begin
          issued_d = 1'b0;
          if (acc_rdata[SrRarc]) begin
            nack_d  = 1'b1;
            state_d = StStop;
            step_d  = '0;
          end else if (acc_rdata[SrTrrdy] || !acc_rdata[SrTip]) begin
            state_d = (left_q != 4'd0) ? StLoad : StStop;
            step_d  = '0;
          end
          // Otherwise stay and re-read SR.
        end
      end
      StLoad: begin
        // No timeout here: a stalled producer simply holds the bus.
        if (wr_valid_i) begin
          byte_d  = wr_data_i;
          left_d  = left_q - 4'd1;
          state_d = StSendByte;
          step_d  = '0;
        end
      end
      StStop: begin
        if (acc_to) begin
          // Second timeout: give up on the bus and return straight to IDLE.
          to_d     = 1'b1;
          issued_d = 1'b0;
          state_d  = StIdle;
          step_d   = '0;
          done_d   = 1'b1;
        end else if (acc_ack) begin
          issued_d = 1'b0;
          if (step_q == 2'd0) begin
            step_d = 2'd1;
          end else if (!acc_rdata[SrBusy]) begin
            state_d = StIdle;
            step_d  = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = StInit;
        step_d  = '0;
      end
    endcase
  end

  // Output logic: the access request for the current step plus handshakes.
  always_comb begin
    acc_req   = 1'b0;
    acc_we    = 1'b1;
    acc_off   = OffCr1;
    acc_wdata = 8'h00;
    unique case (state_q)
      StInit: begin
        acc_req = !issued_q;
        if (step_q == 2'd0) begin
          acc_off   = OffBrlsb;
          acc_wdata = PRESCALE[7:0];
        end else if (step_q == 2'd1) begin
          acc_off   = OffBrmsb;
          acc_wdata = {6'b0, PRESCALE[9:8]};
        end else begin
          acc_off   = OffCr1;
          acc_wdata = Cr1I2cEn;
        end
      end
      StSendAddr: begin
        acc_req = !issued_q;
        if (step_q == 2'd0) begin
          acc_off   = OffTxdr;
          acc_wdata = {addr_q, 1'b0};
        end else begin
          acc_off   = OffCmdr;
          acc_wdata = CmdrSta | CmdrWr;
        end
      end
      StSendByte: begin
        acc_req = !issued_q;
        if (step_q == 2'd0) begin
          acc_off   = OffTxdr;
          acc_wdata = byte_q;
        end else begin
          acc_off   = OffCmdr;
          acc_wdata = CmdrWr;
        end
      end
      StPoll: begin
        acc_req = !issued_q;
        acc_we  = 1'b0;
        acc_off = OffSr;
      end
      StStop: begin
        acc_req = !issued_q;
        if (step_q == 2'd0) begin
          acc_off   = OffCmdr;
          acc_wdata = CmdrSto;
        end else begin
          acc_we  = 1'b0;
          acc_off = OffSr;
        end
      end
      default: begin
        acc_req = 1'b0;
      end
    endcase
    cmd_ready_o = (state_q == StIdle);
    wr_ready_o  = (state_q == StLoad);
    busy_o      = (state_q != StIdle);
  end

  assign done_o    = done_q;
  assign nack_o    = nack_q;
  assign timeout_o = to_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Scoreboard bench for i2c_write_sequencer: a behavioural I2C hard-IP bus model
// checks each completed write against an expected queue, and a done monitor
// checks per-transaction status against a second queue.
module tb_i2c_write_sequencer;

  localparam int unsigned TIMEOUT = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [6:0] cmd_addr;
  logic [3:0] cmd_len;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic       done, nack, timeout, busy;
  logic       sbrw, sbstb, sback;
  logic [7:0] sbadr, sbdat_to, sbdat_from;

  always #5 clk = ~clk;

  i2c_write_sequencer #(
    .BUS_ADDR74(4'b0001),
    .PRESCALE  (10'd30),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .cmd_valid_i            (cmd_valid),
    .cmd_ready_o            (cmd_ready),
    .cmd_addr_i             (cmd_addr),
    .cmd_len_i              (cmd_len),
    .wr_data_i              (wr_data),
    .wr_valid_i             (wr_valid),
    .wr_ready_o             (wr_ready),
    .done_o                 (done),
    .nack_o                 (nack),
    .timeout_o              (timeout),
    .busy_o                 (busy),
    .sbrw_o                 (sbrw),
    .sbstb_o                (sbstb),
    .sbadr_o                (sbadr),
    .sbdat_to_peripheral_o  (sbdat_to),
    .sbdat_from_peripheral_i(sbdat_from),
    .sback_i                (sback)
  );

  typedef struct packed {
    logic       nk;
    logic       to;
    logic [4:0] consumed;
  } st_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [15:0] exp_wr[$];   // {sbadr, data} of expected completed writes
  st_t         exp_st[$];
  logic [7:0]  byte_q[$];   // bytes offered on the wr stream
  logic [7:0]  pend[$];     // payload for the next transaction
  int          consumed = 0;
  bit          nack_mode = 0, withhold_cmdr = 0, stall_byte2 = 0;
  int          to_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // Bus model: random ack latency, SR contents derived from the last command.
  bit         in_acc = 0, held = 0;
  int         lat = 0, hold_cnt = 0, poll_busy = 0;
  logic [7:0] last_cmd = 8'h00, a0, d0;
  logic       rw0;
  initial begin
    logic [15:0] e;
    sback = 1'b0;
    sbdat_from = 8'h00;
    forever begin
      @(negedge clk);
      sback = 1'b0;
      if (!sbstb) begin
        if (in_acc && held) to_cycles = hold_cnt;
        in_acc = 0;
        held   = 0;
      end else begin
        if (!in_acc) begin
          in_acc = 1; hold_cnt = 0; lat = $urandom_range(0, 3);
          a0 = sbadr; d0 = sbdat_to; rw0 = sbrw; held = 0;
          if (sbrw && sbadr == 8'h19 && withhold_cmdr) begin
            held = 1; withhold_cmdr = 0;
          end
          if (sbrw && sbadr == 8'h1D && stall_byte2 && consumed >= 2) held = 1;
        end
        hold_cnt++;
        if (!held) begin
          if (lat > 0) lat--;
          else begin
            check("bus_stable", {23'b0, sbrw, sbadr, sbdat_to}, {23'b0, rw0, a0, d0});
            if (sbrw) begin
              if (exp_wr.size() == 0) begin
                fail_now($sformatf("unexpected_write got %02h=%02h required none",
                                   sbadr, sbdat_to));
              end else begin
                e = exp_wr.pop_front();
                check("bus_write", {16'b0, sbadr, sbdat_to}, {16'b0, e});
              end
              if (sbadr == 8'h19) begin
                last_cmd  = sbdat_to;
                poll_busy = $urandom_range(0, 2);
              end
            end else begin
              check("bus_read_addr", {24'b0, sbadr}, 32'h1C);
              if (poll_busy > 0) begin
                poll_busy--;
                sbdat_from = 8'hC0;                       // TIP, BUSY
              end else if (last_cmd == 8'h40) sbdat_from = 8'h00;
              else if (last_cmd == 8'h90 && nack_mode) sbdat_from = 8'h60;  // RARC
              else sbdat_from = 8'h44;                    // BUSY, TRRDY
            end
            sback = 1'b1;
          end
        end
      end
    end
  end

  // Payload producer with random stalls; counts bytes the DUT will take.
  initial begin
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (byte_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        wr_valid = 1'b1;
        wr_data  = byte_q[0];
        if (wr_ready && !rst) begin
          void'(byte_q.pop_front());
          consumed++;
        end
      end else begin
        wr_valid = 1'b0;
        wr_data  = 8'($urandom);
      end
    end
  end

  // Done monitor.
  initial begin
    st_t s;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_st.size() == 0) fail_now("unexpected_done");
        else begin
          s = exp_st.pop_front();
          check("done_nack", {31'b0, nack}, {31'b0, s.nk});
          check("done_timeout", {31'b0, timeout}, {31'b0, s.to});
          check("bytes_consumed", consumed, {27'b0, s.consumed});
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic push_init();
    exp_wr.push_back(16'h1A1E);
    exp_wr.push_back(16'h1B00);
    exp_wr.push_back(16'h1880);
  endtask

  task automatic wait_ready(input string name);
    int cyc = 0;
    while (!cmd_ready && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check(name, {31'b0, cmd_ready}, 32'd1);
  endtask

  task automatic fill(input int len);
    pend.delete();
    for (int i = 0; i < len; i++) pend.push_back(8'($urandom));
  endtask

  task automatic issue(input logic [6:0] a, input logic [3:0] len);
    wait_ready("cmd_ready_wait");
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = len;
    @(negedge clk);
    cmd_addr = 7'($urandom);
    cmd_len  = 4'($urandom);
    check("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
    check("busy_in_txn", {31'b0, busy}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [6:0] a, input logic [3:0] len, input bit nk,
                         input bit wh);
    st_t s;
    int  cyc = 0;
    consumed = 0; nack_mode = nk; withhold_cmdr = wh;
    exp_wr.push_back({8'h1D, a, 1'b0});
    if (!wh) exp_wr.push_back(16'h1990);
    foreach (pend[i]) begin
      byte_q.push_back(pend[i]);
      if (!nk && !wh) begin
        exp_wr.push_back({8'h1D, pend[i]});
        exp_wr.push_back(16'h1910);
      end
    end
    exp_wr.push_back(16'h1940);
    s.nk = nk; s.to = wh; s.consumed = (nk || wh) ? 5'd0 : 5'(len);
    exp_st.push_back(s);
    issue(a, len);
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) fail_now("done_wait expired");
    else begin
      @(negedge clk);
      check("done_pulse_width", {31'b0, done}, 32'd0);
    end
    repeat (3) @(negedge clk);
    check("nack_held", {31'b0, nack}, {31'b0, nk});
    check("timeout_held", {31'b0, timeout}, {31'b0, wh});
    check("idle_ready", {30'b0, cmd_ready, busy}, 32'd2);
    check("writes_outstanding", exp_wr.size(), 0);
    if (wh) check("timeout_cycles", to_cycles, TIMEOUT);
    byte_q.delete();
    nack_mode = 0;
  endtask

  initial begin
    int cyc;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    repeat (3) @(negedge clk);
    check("rst_sbstb", {31'b0, sbstb}, 0);
    check("rst_sbrw", {31'b0, sbrw}, 0);
    check("rst_sbadr", {24'b0, sbadr}, 0);
    check("rst_sbdat", {24'b0, sbdat_to}, 0);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 0);
    check("rst_wr_ready", {31'b0, wr_ready}, 0);
    check("rst_flags", {29'b0, done, nack, timeout}, 0);
    check("rst_busy", {31'b0, busy}, 1);
    push_init();
    rst = 1'b0;
    wait_ready("init_ready");
    check("init_writes_left", exp_wr.size(), 0);

    pend.delete(); pend.push_back(8'hAB); pend.push_back(8'hCD);
    run_txn(7'h3C, 4'd2, 0, 0);
    fill(3);
    run_txn(7'h50, 4'd3, 1, 0);
    pend.delete();
    run_txn(7'h48, 4'd0, 0, 0);
    fill(2);
    run_txn(7'h22, 4'd2, 0, 1);
    for (int t = 0; t < 8; t++) begin
      int  len = $urandom_range(0, 15);
      bit  nk  = ($urandom_range(0, 3) == 0);
      fill(len);
      run_txn(7'($urandom), 4'(len), nk, 0);
    end

    // Reset while the second of four payload bytes is on the bus.
    fill(4);
    pend[1] = pend[0] ^ 8'hFF;
    consumed = 0; stall_byte2 = 1;
    exp_wr.push_back({8'h1D, 7'h33, 1'b0});
    exp_wr.push_back(16'h1990);
    exp_wr.push_back({8'h1D, pend[0]});
    exp_wr.push_back(16'h1910);
    foreach (pend[i]) byte_q.push_back(pend[i]);
    issue(7'h33, 4'd4);
    cyc = 0;
    while (!(sbstb && sbadr == 8'h1D && sbdat_to == pend[1]) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("byte2_on_bus", {31'b0, sbstb}, 1);
    #3 rst = 1'b1;
    #1 check("rst_drops_sbstb", {31'b0, sbstb}, 0);
    check("rst_busy_mid", {31'b0, busy}, 1);
    check("writes_before_reset", exp_wr.size(), 0);
    exp_wr.delete(); exp_st.delete(); byte_q.delete();
    stall_byte2 = 0;
    repeat (2) @(negedge clk);
    push_init();
    rst = 1'b0;
    wait_ready("reinit_ready");
    check("reinit_writes_left", exp_wr.size(), 0);
    fill(3);
    run_txn(7'h11, 4'd3, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
